// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer sharing the single imem port
// between the program loader and the CPU fetch path.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   run_en                CPU may fetch (level)
//   load_req              loader requests the imem port (level)
//   load_we/addr/data     loader write strobe, word address, data
//   stall                 hazard unit: hold PC and IF/ID
//   br_taken, br_target   ID-stage redirect request and byte target
//   imem_a/we/d, imem_spo imem port (async read data on imem_spo)
//   ifid_pc/instr/valid   IF/ID pipeline register
//   loading               loader owns the imem port
//   load_cnt              words written in the current load session
//   fault                 misaligned redirect trapped
module imem_fetch_ctrl #(
    parameter int          AW        = 11,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run_en,
    input  logic          load_req,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          stall,
    input  logic          br_taken,
    input  logic [31:0]   br_target,
    output logic [AW-1:0] imem_a,
    output logic          imem_we,
    output logic [31:0]   imem_d,
    input  logic [31:0]   imem_spo,
    output logic [31:0]   ifid_pc,
    output logic [31:0]   ifid_instr,
    output logic          ifid_valid,
    output logic          loading,
    output logic [AW:0]   load_cnt,
    output logic          fault
);

    localparam logic [1:0] S_HALT  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [AW:0] load_cnt_q, load_cnt_d;
    logic        fault_q, fault_d;

    // The loader owns the port only while in LOAD; otherwise the PC reads.
    always_comb begin
        imem_a  = pc_q[AW+1:2];
        imem_we = 1'b0;
        imem_d  = 32'h0;
        if (state_q == S_LOAD) begin
            imem_a  = load_addr;
            imem_we = load_we;
            imem_d  = load_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        load_cnt_d   = load_cnt_q;
        fault_d      = fault_q;
        case (state_q)
            S_HALT: begin
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
                if (load_req) begin
                    state_d    = S_LOAD;
                    load_cnt_d = '0;
                end else if (run_en) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
                if (load_we && load_cnt_q != CNT_MAX) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
                if (!load_req) begin
                    state_d = S_HALT;
                    pc_d    = RESET_PC;
                    fault_d = 1'b0;
                end
            end
            S_RUN: begin
                if (load_req) begin
                    state_d      = S_LOAD;
                    load_cnt_d   = '0;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end else if (!run_en) begin
                    state_d      = S_HALT;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end else if (stall) begin
                    // Hold everything; ID re-presents the branch later.
                end else if (br_taken && br_target[1:0] != 2'b00) begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end else if (br_taken) begin
                    // The word read this cycle is the wrong-path slot.
                    pc_d         = br_target;
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end else begin
                    pc_d         = pc_q + 32'd4;
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = imem_spo;
                    ifid_valid_d = 1'b1;
                end
            end
            S_FAULT: begin
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
                if (load_req) begin
                    state_d    = S_LOAD;
                    load_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HALT;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            load_cnt_q   <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            load_cnt_q   <= load_cnt_d;
            fault_q      <= fault_d;
        end
    end

    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;
    assign loading    = (state_q == S_LOAD);
    assign load_cnt   = load_cnt_q;
    assign fault      = fault_q;

endmodule
